uart_rx_deser: RTL and testbench

UART_RX_DESER -- requirements
Module: uart_rx_deser

---
 rtl/uart_rx_deser.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_deser.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: oversampling UART receiver with a 2-flop input synchronizer and a break-aware FSM.
// Define UART_RX_PARITY_EN to add one even-parity bit after the data bits.
module uart_rx_deser #(
  parameter int unsigned ASCIIBIT     = 8,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                rx,
  output logic [ASCIIBIT-1:0] data,
  output logic                receive_done,
  output logic                frame_err,
  output logic                parity_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = (ASCIIBIT > 1) ? $clog2(ASCIIBIT) : 1;
  localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(ASCIIBIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;
`endif

  state_e r_state;
  state_e w_state_next;

  logic                r_rx_meta;
  logic                r_rx_sync;
  logic [CntW-1:0]     r_cnt;
  logic [IdxW-1:0]     r_idx;
  logic [ASCIIBIT-1:0] r_shift;
  logic [ASCIIBIT-1:0] r_data;
  logic                r_done;
  logic                r_ferr;
`ifdef UART_RX_PARITY_EN
  logic                r_par_bit;
  logic                r_perr;
  logic                w_par_en;
  logic                w_perr;
`endif

  logic w_half_end;
  logic w_bit_end;
  logic w_cnt_run;
  logic w_cnt_wrap;
  logic w_shift_en;
  logic w_idx_clr;
  logic w_done;
  logic w_ferr;

  assign w_half_end = (r_cnt == HalfEnd);
  assign w_bit_end  = (r_cnt == BitEnd);

  // Both flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (!r_rx_sync) w_state_next = StStart;
      end
      StStart: begin
        // Start bit must still be low at its midpoint, else it was a glitch.
        if (w_half_end) w_state_next = r_rx_sync ? StIdle : StData;
      end
      StData: begin
        if (w_bit_end && (r_idx == LastIdx)) begin
`ifdef UART_RX_PARITY_EN
          w_state_next = StParity;
`else
          w_state_next = StStop;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (w_bit_end) w_state_next = StStop;
      end
`endif
      StStop: begin
        if (w_bit_end) w_state_next = r_rx_sync ? StIdle : StBreak;
      end
      StBreak: begin
        if (r_rx_sync) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_cnt_run  = 1'b0;
    w_cnt_wrap = 1'b0;
    w_shift_en = 1'b0;
    w_idx_clr  = 1'b0;
    w_done     = 1'b0;
    w_ferr     = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_en   = 1'b0;
    w_perr     = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        w_idx_clr = 1'b1;
      end
      StStart: begin
        w_cnt_run  = 1'b1;
        w_cnt_wrap = w_half_end;
      end
      StData: begin
        w_cnt_run  = 1'b1;
        w_cnt_wrap = w_bit_end;
        w_shift_en = w_bit_end;
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        w_cnt_run  = 1'b1;
        w_cnt_wrap = w_bit_end;
        w_par_en   = w_bit_end;
      end
`endif
      StStop: begin
        w_cnt_run  = 1'b1;
        w_cnt_wrap = w_bit_end;
        if (w_bit_end) begin
          // Framing error wins over parity error.
          if (!r_rx_sync) w_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (r_par_bit != (^r_shift)) w_perr = 1'b1;
`endif
          else w_done = 1'b1;
        end
      end
      StBreak: begin
        w_idx_clr = 1'b1;
      end
      default: begin
        w_idx_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (!w_cnt_run || w_cnt_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end

      if (w_idx_clr) begin
        r_idx <= '0;
      end else if (w_shift_en) begin
        r_idx <= (r_idx == LastIdx) ? '0 : r_idx + IdxW'(1);
      end

      // LSB arrives first, so shift in from the top.
      if (w_shift_en) begin
        r_shift <= {r_rx_sync, r_shift[ASCIIBIT-1:1]};
      end

      if (w_done) begin
        r_data <= r_shift;
      end

      r_done <= w_done;
      r_ferr <= w_ferr;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_par_bit <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      if (w_par_en) r_par_bit <= r_rx_sync;
      r_perr <= w_perr;
    end
  end

  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

  assign data         = r_data;
  assign receive_done = r_done;
  assign frame_err    = r_ferr;

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: scoreboard bench for uart_rx_deser at CLKS_PER_BIT = 16, ASCIIBIT = 8.
`timescale 1ns/1ps
module tb_uart_rx_deser;

  localparam int unsigned Cpb = 16;
  localparam int unsigned Nb  = 8;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned ParBits = 1;
`else
  localparam int unsigned ParBits = 0;
`endif
  // Falling edge of start bit to receive_done, including sync and output register.
  localparam int unsigned ExpLat = (Nb + 1 + ParBits) * Cpb + Cpb / 2 + 3;

  logic         clk;
  logic         reset_b;
  logic         rx;
  logic [Nb-1:0] data;
  logic         receive_done;
  logic         frame_err;
  logic         parity_err;

  uart_rx_deser #(
    .ASCIIBIT    (Nb),
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk         (clk),
    .reset_b     (reset_b),
    .rx          (rx),
    .data        (data),
    .receive_done(receive_done),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = receive_done, 1 = frame_err, 2 = parity_err; val = data expected on that pulse
  typedef struct packed {
    logic [1:0]    kind;
    logic [Nb-1:0] val;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [1:0]    mon_kind;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_pulses = 0;
  int            n_pushed = 0;
  int            pre_pulses;
  int unsigned   cyc      = 0;
  int unsigned   t_start  = 0;
  int unsigned   lat;
  logic [Nb-1:0] last_good;
  logic [Nb-1:0] part;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (Cpb) @(negedge clk);
  endtask

  // stop_b = level of the stop bit; par_flip inverts the even-parity bit when parity is built in.
  task automatic send_frame(input logic [Nb-1:0] d, input logic stop_b, input logic par_flip);
    exp_t e;
    if (!stop_b) begin
      e.kind = 2'd1;
      e.val  = last_good;
    end else if (par_flip && (ParBits != 0)) begin
      e.kind = 2'd2;
      e.val  = last_good;
    end else begin
      e.kind    = 2'd0;
      e.val     = d;
      last_good = d;
    end
    exp_q.push_back(e);
    n_pushed++;
    t_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < int'(Nb); i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop_b);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_b && (receive_done || frame_err || parity_err)) begin
      n_pulses++;
      check_eq("pulse_onehot", 32'(receive_done) + 32'(frame_err) + 32'(parity_err), 32'd1);
      mon_kind = receive_done ? 2'd0 : (frame_err ? 2'd1 : 2'd2);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", {29'd0, receive_done, frame_err, parity_err}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("pulse_kind", {30'd0, mon_kind}, {30'd0, mon_e.kind});
        check_eq("pulse_data", {24'd0, data}, {24'd0, mon_e.val});
        if (receive_done) begin
          lat = cyc - t_start;
          check_eq("done_latency", {31'd0, (lat + 3 >= ExpLat) && (lat <= ExpLat + 3)}, 32'd1);
        end
      end
    end
  end

  initial begin
    reset_b   = 1'b0;
    rx        = 1'b1;
    last_good = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_data", {24'd0, data}, 32'd0);
    check_eq("rst_pulses", {29'd0, receive_done, frame_err, parity_err}, 32'd0);
    reset_b = 1'b1;
    idle(4);

    send_frame(8'h35, 1'b1, 1'b0);
    idle(Cpb);
    check_eq("data_hold_35", {24'd0, data}, 32'h35);

    // Back-to-back, no idle between stop and next start.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(Cpb);
    check_eq("data_hold_ff", {24'd0, data}, 32'hFF);

    pre_pulses = n_pulses;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(3 * Cpb);
    check_eq("glitch_quiet", n_pulses, pre_pulses);

    // Stop bit low, then a held break that must not retrigger.
    send_frame(8'hA5, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (2 * Cpb) @(negedge clk);
    idle(Cpb);
    check_eq("ferr_data_kept", {24'd0, data}, 32'hFF);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(Cpb);

    // Reset lands in the middle of bit 4 of a frame.
    part = 8'h55;
    rx   = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 4; i++) send_bit(part[i]);
    rx = part[4];
    repeat (Cpb / 2) @(negedge clk);
    reset_b = 1'b0;
    #1;
    check_eq("rst_mid_data_now", {24'd0, data}, 32'd0);
    rx = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rst_mid_data", {24'd0, data}, 32'd0);
      check_eq("rst_mid_pulses", {29'd0, receive_done, frame_err, parity_err}, 32'd0);
    end
    reset_b   = 1'b1;
    last_good = '0;
    idle(2 * Cpb);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(Cpb);
    check_eq("data_hold_7e", {24'd0, data}, 32'h7E);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1);
    idle(Cpb);
    check_eq("perr_data_kept", {24'd0, data}, 32'h7E);
    send_frame(8'h03, 1'b1, 1'b0);
    idle(Cpb);
    check_eq("data_hold_03", {24'd0, data}, 32'h03);
`endif

    for (int i = 0; (i < 400) && (exp_q.size() != 0); i++) @(negedge clk);
    check_eq("exp_q_drained", exp_q.size(), 32'd0);
    check_eq("pulse_count", n_pulses, n_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
